fifo_tmo: RTL and testbench
===========================

FIFO_TMO -- requirements
Module: fifo_tmo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=4).
REQ-002 SHALL have parameter WIDTH, default 64, data bits per entry.
REQ-003 SHALL have parameter TMO_BITS, default 14, idle timeout = 2^TMO_BITS cycles.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold (count >= AF_LVL).
REQ-005 SHALL have parameter AE_LVL, default 2, almost_empty threshold (count <= AE_LVL).
REQ-006 SHALL have port iclk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port irstn  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port iwren  in  1  write request.
REQ-009 SHALL have port din  in  WIDTH  write data.
REQ-010 SHALL have port irden  in  1  read request.
REQ-011 SHALL have port dout  out  WIDTH  registered read data.
REQ-012 SHALL have port dvalid  out  1  dout updated by a pop in previous cycle.
REQ-013 SHALL have port dtmo  out  1  with dvalid: pop was timeout-initiated.
REQ-014 SHALL have ports empty, full, almost_full, almost_empty  out  1 each  status flags.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH.

Function
REQ-016 SHALL store DEPTH entries; pointers carry one extra wrap bit; full when count==DEPTH, empty when count==0.
REQ-017 SHALL accept a write when iwren && !full, using flags as registered at cycle start; write while full is dropped, no state change.
REQ-018 SHALL pop when (irden || state==DRAIN) && !empty; read while empty is ignored; at most one pop per cycle.
REQ-019 SHALL load dout with the popped entry at the popping edge; dvalid high exactly the following cycle; dout holds otherwise.
REQ-020 SHALL allow simultaneous write and pop: both occur, count unchanged; when full only the pop occurs; when empty only the write occurs (no bypass).
REQ-021 SHALL wrap pointers modulo DEPTH; data order strictly FIFO across wraps.
REQ-022 SHALL run FSM IDLE/WAIT/DRAIN: IDLE->WAIT on accepted write; WAIT->IDLE when count reaches 0.
REQ-023 SHALL in WAIT count consecutive cycles with no accepted write and no pop; any accepted write or pop clears the timer.
REQ-024 SHALL enter DRAIN after 2^TMO_BITS consecutive idle WAIT cycles; timer saturates, never wraps.
REQ-025 SHALL in DRAIN pop one entry per cycle; DRAIN->IDLE when the pop empties the FIFO; accepted write in DRAIN -> WAIT with timer cleared (same-cycle pop still occurs).
REQ-026 SHALL assert dtmo with dvalid only for pops occurring in DRAIN with irden low.

Reset
REQ-027 SHALL on irstn low asynchronously set: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, dout 0, dvalid 0, dtmo 0, timer 0, state IDLE; storage array not reset.
REQ-028 SHALL discard all contents on reset mid-operation, including mid-DRAIN; first post-reset read returns nothing until a write.

Configuration
REQ-029 SHALL compile timeout drain only when FIFO_TMO_DRAIN_EN is defined; without it: no timer, FSM held IDLE, pops only via irden, dtmo constant 0, TMO_BITS unused.

Verification
REQ-030 SHALL test fill: DEPTH=16, 16 writes 0..15 -> full=1, count=16, 17th write dropped; 16 reads return 0..15, dvalid one cycle after each read, then empty=1.
REQ-031 SHALL test wrap: 10 writes/10 reads twice, then 12 writes -> reads return exact write order, count tracks 0..12.
REQ-032 SHALL test simultaneous write+read at count=16 -> count 15 next cycle; at count=5 -> count stays 5; at count=0 -> count 1, dvalid 0.
REQ-033 SHALL test timeout (macro defined, TMO_BITS=4): 3 writes cycles 0-2, idle -> DRAIN from cycle 19, dvalid+dtmo cycles 20-22, then IDLE, empty=1.
REQ-034 SHALL test write during DRAIN and async reset mid-DRAIN -> DRAIN aborts to WAIT with timer 0; reset -> all outputs at REQ-027 values immediately.
REQ-035 SHALL test thresholds: count crossing AF_LVL=14 and AE_LVL=2 toggles almost_full/almost_empty same cycle as count.

Source files
------------

// File: rtl/fifo_tmo.sv
// Synchronous FIFO with registered read data and optional idle-timeout auto-drain.
// Define FIFO_TMO_DRAIN_EN to build the timeout drain FSM; otherwise pops come only from irden.
module fifo_tmo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned TMO_BITS = 14,
  parameter int unsigned AF_LVL   = DEPTH - 2,
  parameter int unsigned AE_LVL   = 2
) (
  input  logic                   iclk,
  input  logic                   irstn,
  input  logic                   iwren,
  input  logic [WIDTH-1:0]       din,
  input  logic                   irden,
  output logic [WIDTH-1:0]       dout,
  output logic                   dvalid,
  output logic                   dtmo,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);
  localparam logic [CW-1:0] AeLvlC = CW'(AE_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             wr_acc;
  logic             pop;
  logic             drain;

  // Occupancy follows from the registered pointers, so every flag reflects cycle-start state.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DepthC);
  assign almost_full  = (count >= AfLvlC);
  assign almost_empty = (count <= AeLvlC);

  assign wr_acc = iwren & ~full;
  assign pop    = (irden | drain) & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    dvalid_d = pop;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

`ifdef FIFO_TMO_DRAIN_EN
  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e              state_q, state_d;
  logic [TMO_BITS-1:0] timer_q, timer_d;
  logic [CW-1:0]       count_d;
  logic                dtmo_q, dtmo_d;

  assign drain   = (state_q == StDrain);
  assign count_d = wr_ptr_d - rd_ptr_d;
  assign dtmo_d  = pop & drain & ~irden;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (wr_acc) state_d = StWait;
      end
      StWait: begin
        if (wr_acc || pop) begin
          timer_d = '0;
          if (count_d == '0) state_d = StIdle;
        end else if (&timer_q) begin
          // Timer saturates at all-ones; this idle cycle completes the full timeout.
          state_d = StDrain;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDrain: begin
        if (wr_acc) begin
          state_d = StWait;
          timer_d = '0;
        end else if (pop && (count == CW'(1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state_q <= StIdle;
      timer_q <= '0;
      dtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dtmo_q  <= dtmo_d;
    end
  end

  assign dtmo = dtmo_q;
`else
  assign drain = 1'b0;
  assign dtmo  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_tmo.sv
// Self-checking bench for fifo_tmo: directed scenarios plus randomized traffic against a
// queue-based reference model. Timeout scenarios run when FIFO_TMO_DRAIN_EN is defined.
module tb_fifo_tmo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 64;
  localparam int TMO   = 4;

  logic             iclk = 1'b0;
  logic             irstn = 1'b1;
  logic             iwren = 1'b0;
  logic             irden = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             dvalid, dtmo, empty, full, almost_full, almost_empty;
  logic [4:0]       count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents plus expected registered outputs and drain mode.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_dvalid, m_dtmo;
  int               m_mode;  // 0 idle, 1 waiting for timeout, 2 draining
  int               m_idle;

  fifo_tmo #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .TMO_BITS(TMO),
    .AF_LVL  (14),
    .AE_LVL  (2)
  ) dut (
    .iclk        (iclk),
    .irstn       (irstn),
    .iwren       (iwren),
    .din         (din),
    .irden       (irden),
    .dout        (dout),
    .dvalid      (dvalid),
    .dtmo        (dtmo),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] exp_status();
    int n;
    n = q.size();
    return {5'(n), n == 0, n == DEPTH, n >= 14, n <= 2, m_dvalid, m_dtmo};
  endfunction

  function automatic logic [10:0] obs_status();
    return {count, empty, full, almost_full, almost_empty, dvalid, dtmo};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout   = '0;
    m_dvalid = 1'b0;
    m_dtmo   = 1'b0;
    m_mode   = 0;
    m_idle   = 0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
    int n;
    bit acc, pop, drn;
    n   = q.size();
    acc = wr && (n < DEPTH);
`ifdef FIFO_TMO_DRAIN_EN
    drn = (m_mode == 2);
`else
    drn = 1'b0;
`endif
    pop = (rd || drn) && (n > 0);
    if (pop) begin
      m_dout   = q.pop_front();
      m_dvalid = 1'b1;
      m_dtmo   = drn && !rd;
    end else begin
      m_dvalid = 1'b0;
      m_dtmo   = 1'b0;
    end
    if (acc) q.push_back(d);
`ifdef FIFO_TMO_DRAIN_EN
    case (m_mode)
      0: if (acc) begin m_mode = 1; m_idle = 0; end
      1: begin
        if (acc || pop) begin
          m_idle = 0;
          if (q.size() == 0) m_mode = 0;
        end else begin
          m_idle++;
          if (m_idle == (1 << TMO)) m_mode = 2;
        end
      end
      default: begin
        if (acc) begin m_mode = 1; m_idle = 0; end
        else if (q.size() == 0) m_mode = 0;
      end
    endcase
`endif
  endtask

  // One clock: drive at the falling edge, let the rising edge act, return at the next fall.
  task automatic cycle(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
    iwren = wr;
    irden = rd;
    din   = d;
    model_step(wr, rd, d);
    @(posedge iclk);
    @(negedge iclk);
    iwren = 1'b0;
    irden = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    #2 irstn = 1'b0;
    model_reset();
    @(negedge iclk);
    irstn = 1'b1;
  endtask

  task automatic test_reset();
    #1 irstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_status() !== 11'b00000_1_0_0_1_0_0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: got st=%b dout=%h, want st=%b dout=0", obs_status(), dout,
               11'b00000_1_0_0_1_0_0);
    end
    @(negedge iclk);
    irstn = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 1'b0, (i < 16) ? WIDTH'(i) : WIDTH'(99));
      checks++;
      if (obs_status() !== exp_status()) begin
        errors++;
        $display("FAIL fill_write %0d: got st=%b, want st=%b", i, obs_status(), exp_status());
      end
      if (i >= 15) begin
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
          errors++;
          $display("FAIL fill_full %0d: got count=%0d full=%b, want count=16 full=1", i, count,
                   full);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (obs_status() !== exp_status() || dvalid !== 1'b1 || dout !== WIDTH'(i)) begin
        errors++;
        $display("FAIL fill_read %0d: got st=%b dv=%b dout=%0d, want st=%b dv=1 dout=%0d", i,
                 obs_status(), dvalid, dout, exp_status(), i);
      end
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (empty !== 1'b1 || dvalid !== 1'b0 || dout !== WIDTH'(15)) begin
      errors++;
      $display("FAIL fill_empty: got empty=%b dv=%b dout=%0d, want empty=1 dv=0 dout=15", empty,
               dvalid, dout);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] w;
    for (int pass = 0; pass < 3; pass++) begin
      int n;
      n = (pass == 2) ? 12 : 10;
      for (int i = 0; i < n; i++) begin
        w = {$urandom, $urandom};
        exp_q.push_back(w);
        cycle(1'b1, 1'b0, w);
        checks++;
        if (count !== 5'(i + 1) || obs_status() !== exp_status()) begin
          errors++;
          $display("FAIL wrap_count p%0d i%0d: got count=%0d st=%b, want count=%0d st=%b", pass,
                   i, count, obs_status(), i + 1, exp_status());
        end
      end
      for (int i = 0; i < n; i++) begin
        w = exp_q.pop_front();
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (dvalid !== 1'b1 || dout !== w || count !== 5'(n - 1 - i)) begin
          errors++;
          $display("FAIL wrap_order p%0d i%0d: got dv=%b dout=%h count=%0d, want dv=1 dout=%h %0d",
                   pass, i, dvalid, dout, count, w, n - 1 - i);
        end
      end
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, WIDTH'(100 + i));
    cycle(1'b1, 1'b1, WIDTH'(200));
    checks++;
    if (count !== 5'd15 || dvalid !== 1'b1 || dout !== WIDTH'(100)) begin
      errors++;
      $display("FAIL simul_full: got count=%0d dv=%b dout=%0d, want count=15 dv=1 dout=100",
               count, dvalid, dout);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, WIDTH'(201));
    checks++;
    if (count !== 5'd5 || dvalid !== 1'b1 || obs_status() !== exp_status()) begin
      errors++;
      $display("FAIL simul_mid: got count=%0d dv=%b, want count=5 dv=1", count, dvalid);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, WIDTH'(202));
    checks++;
    if (count !== 5'd1 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: got count=%0d dv=%b, want count=1 dv=0", count, dvalid);
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (dout !== WIDTH'(202) || dvalid !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_drain: got dout=%0d dv=%b empty=%b, want 202 1 1", dout, dvalid, empty);
    end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i));
      checks++;
      if (almost_full !== (i >= 14) || almost_empty !== (i <= 2) || count !== 5'(i)) begin
        errors++;
        $display("FAIL thr_up %0d: got af=%b ae=%b count=%0d, want af=%b ae=%b", i, almost_full,
                 almost_empty, count, i >= 14, i <= 2);
      end
    end
    for (int i = 15; i >= 0; i--) begin
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (almost_full !== (i >= 14) || almost_empty !== (i <= 2) || count !== 5'(i)) begin
        errors++;
        $display("FAIL thr_down %0d: got af=%b ae=%b count=%0d, want af=%b ae=%b", i, almost_full,
                 almost_empty, count, i >= 14, i <= 2);
      end
    end
  endtask

  task automatic test_random();
    int wp, rp;
    for (int seg = 0; seg < 16; seg++) begin
      unique case (seg % 4)
        0: begin wp = 80; rp = 30; end
        1: begin wp = 30; rp = 80; end
        2: begin wp = 60; rp = 60; end
        default: begin wp = 15; rp = 5; end
      endcase
      for (int i = 0; i < 30; i++) begin
        bit wr, rd;
        wr = ($urandom_range(0, 99) < wp);
        rd = ($urandom_range(0, 99) < rp);
        cycle(wr, rd, {$urandom, $urandom});
        checks++;
        if (obs_status() !== exp_status() || dout !== m_dout) begin
          errors++;
          $display("FAIL random s%0d c%0d: got st=%b dout=%h, want st=%b dout=%h", seg, i,
                   obs_status(), dout, exp_status(), m_dout);
        end
      end
    end
  endtask

`ifdef FIFO_TMO_DRAIN_EN
  task automatic test_timeout();
    do_reset();
    // Call k drives cycle k; outputs observed after it belong to cycle k+1.
    for (int k = 0; k < 26; k++) begin
      bit exp_pop;
      cycle(k < 3, 1'b0, WIDTH'(k + 50));
      exp_pop = (k + 1 >= 20) && (k + 1 <= 22);
      checks++;
      if (dvalid !== exp_pop || dtmo !== exp_pop || obs_status() !== exp_status()) begin
        errors++;
        $display("FAIL timeout c%0d: got dv=%b tmo=%b st=%b, want dv=%b tmo=%b st=%b", k + 1,
                 dvalid, dtmo, obs_status(), exp_pop, exp_pop, exp_status());
      end
      if (exp_pop) begin
        checks++;
        if (dout !== WIDTH'(k - 19 + 50)) begin
          errors++;
          $display("FAIL timeout_data c%0d: got %0d, want %0d", k + 1, dout, k - 19 + 50);
        end
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL timeout_end: got empty=%b count=%0d, want empty=1 count=0", empty, count);
    end
  endtask

  task automatic test_drain_write();
    do_reset();
    for (int k = 0; k < 20; k++) cycle(k < 4, 1'b0, WIDTH'(k + 70));
    // Cycle 20 is the first drain cycle: write lands and the drain pop still happens.
    cycle(1'b1, 1'b0, WIDTH'(80));
    checks++;
    if (dvalid !== 1'b1 || dtmo !== 1'b1 || dout !== WIDTH'(70) || count !== 5'd4) begin
      errors++;
      $display("FAIL drain_write: got dv=%b tmo=%b dout=%0d count=%0d, want 1 1 70 4", dvalid,
               dtmo, dout, count);
    end
    for (int n = 1; n <= 17; n++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (dtmo !== (n == 17) || dvalid !== (n == 17) || obs_status() !== exp_status()) begin
        errors++;
        $display("FAIL drain_rearm n%0d: got dv=%b tmo=%b, want dv=%b tmo=%b", n, dvalid, dtmo,
                 n == 17, n == 17);
      end
    end
  endtask
`else
  task automatic test_no_drain();
    do_reset();
    for (int k = 0; k < 45; k++) begin
      cycle(k < 3, 1'b0, WIDTH'(k));
      checks++;
      if (dvalid !== 1'b0 || dtmo !== 1'b0 || count !== 5'((k < 3) ? k + 1 : 3)) begin
        errors++;
        $display("FAIL no_drain c%0d: got dv=%b tmo=%b count=%0d, want 0 0 %0d", k, dvalid, dtmo,
                 count, (k < 3) ? k + 1 : 3);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    // Entered with entries present (mid-drain when the timeout feature is built).
    #2 irstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_status() !== 11'b00000_1_0_0_1_0_0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_mid: got st=%b dout=%h, want st=%b dout=0", obs_status(), dout,
               11'b00000_1_0_0_1_0_0);
    end
    @(negedge iclk);
    irstn = 1'b1;
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (dvalid !== 1'b0 || empty !== 1'b1 || dout !== '0) begin
      errors++;
      $display("FAIL reset_read: got dv=%b empty=%b dout=%h, want 0 1 0", dvalid, empty, dout);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_wrap();
    test_simul();
    test_thresholds();
    test_random();
`ifdef FIFO_TMO_DRAIN_EN
    test_timeout();
    test_drain_write();
`else
    test_no_drain();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
